// File: rtl/phase_sequencer_pkg.sv
// Shared definitions for the phase sequencer: state encodings and the default phase count.
package phase_sequencer_pkg;

  localparam int NPHASE_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2,
    ST_ERROR  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/phase_watchdog.sv
// Saturating wait-state counter for the active phase; flags a timeout on the
// MAX_WAIT-th consecutive held cycle.
module phase_watchdog
  import phase_sequencer_pkg::*;
#(
  parameter int WAIT_W   = 8,
  parameter int MAX_WAIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic hold_i,
  output logic timeout_o
);

  logic [WAIT_W-1:0] cnt_q;
  logic [WAIT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (hold_i && (cnt_q != {WAIT_W{1'b1}})) begin
      cnt_d = cnt_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_o = hold_i && (cnt_q == WAIT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/phase_sequencer.sv
// NPHASE-phase instruction sequencer with wait states, flush, halt/resume and watchdog.
// Optional performance counters are built when PHASE_SEQUENCER_PERF_CNT_EN is defined.
module phase_sequencer
  import phase_sequencer_pkg::*;
#(
  parameter int NPHASE   = NPHASE_DEF,
  parameter int WAIT_W   = 8,
  parameter int MAX_WAIT = 255,
  parameter int CNT_W    = 64,
  localparam int IDX_W   = $clog2(NPHASE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NPHASE-1:0] wait_req,
  input  logic              flush,
  input  logic              halt_req,
  input  logic              resume,
  input  logic              clr_err,
  output logic [NPHASE-1:0] phase,
  output logic [NPHASE-1:0] stall,
  output logic [IDX_W-1:0]  phase_idx,
  output logic              retire,
  output logic              halted,
  output logic              err,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  instret_cnt
);

  seq_state_e        state_q, state_d;
  logic [NPHASE-1:0] phase_q, phase_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              retire_c;
  logic              wd_hold, wd_clr, wd_timeout;

  // phase_q is one-hot in RUN and zero elsewhere, so this masks to the active bit.
  assign wd_hold = (state_q == ST_RUN) && |(wait_req & phase_q);
  assign wd_clr  = !wd_hold || flush;

  phase_watchdog #(
    .WAIT_W   (WAIT_W),
    .MAX_WAIT (MAX_WAIT)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (wd_clr),
    .hold_i    (wd_hold),
    .timeout_o (wd_timeout)
  );

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    idx_d    = idx_q;
    retire_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          phase_d = NPHASE'(1);
          idx_d   = '0;
        end
      end
      ST_RUN: begin
        if (wd_timeout) begin
          state_d = ST_ERROR;
          phase_d = '0;
          idx_d   = '0;
        end else if (flush) begin
          phase_d = NPHASE'(1);
          idx_d   = '0;
        end else if (wd_hold) begin
          phase_d = phase_q;
        end else if (idx_q == IDX_W'(NPHASE - 1)) begin
          retire_c = 1'b1;
          idx_d    = '0;
          if (halt_req) begin
            state_d = ST_HALTED;
            phase_d = '0;
          end else begin
            phase_d = NPHASE'(1);
          end
        end else begin
          phase_d = {phase_q[NPHASE-2:0], 1'b0};
          idx_d   = idx_q + IDX_W'(1);
        end
      end
      ST_HALTED: begin
        if (resume) begin
          state_d = ST_RUN;
          phase_d = NPHASE'(1);
          idx_d   = '0;
        end
      end
      ST_ERROR: begin
        if (clr_err) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
    end
  end

  assign phase     = phase_q;
  assign stall     = ~phase_q;
  assign phase_idx = idx_q;
  assign retire    = retire_c;
  assign halted    = (state_q == ST_HALTED);
  assign err       = (state_q == ST_ERROR);

`ifdef PHASE_SEQUENCER_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_q, instret_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (state_q == ST_RUN) cycle_q <= cycle_q + CNT_W'(1);
      if (retire_c)          instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer (NPHASE=5, MAX_WAIT=4).
module tb_phase_sequencer;
  localparam int NPHASE   = 5;
  localparam int WAIT_W   = 8;
  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 32;
  localparam int IDX_W    = $clog2(NPHASE);

  logic              clk = 1'b0;
  logic              rst;
  logic              start, flush, halt_req, resume, clr_err;
  logic [NPHASE-1:0] wait_req;
  logic [NPHASE-1:0] phase, stall;
  logic [IDX_W-1:0]  phase_idx;
  logic              retire, halted, err;
  logic [CNT_W-1:0]  cycle_cnt, instret_cnt;

  int n_vec  = 0;
  int n_fail = 0;

  phase_sequencer #(
    .NPHASE   (NPHASE),
    .WAIT_W   (WAIT_W),
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .wait_req    (wait_req),
    .flush       (flush),
    .halt_req    (halt_req),
    .resume      (resume),
    .clr_err     (clr_err),
    .phase       (phase),
    .stall       (stall),
    .phase_idx   (phase_idx),
    .retire      (retire),
    .halted      (halted),
    .err         (err),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [CNT_W-1:0] perf(input int n);
`ifdef PHASE_SEQUENCER_PERF_CNT_EN
    return CNT_W'(n);
`else
    return CNT_W'(n * 0);
`endif
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; start = 1'b0; flush = 1'b0; halt_req = 1'b0;
    resume = 1'b0; clr_err = 1'b0; wait_req = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
  endtask

  task automatic start_run;
    start = 1'b1;
    step();
    start = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    do_reset();
    n_vec++; if (phase !== 5'b00000) begin n_fail++; $display("FAIL reset_phase got=%b exp=00000", phase); end
    n_vec++; if (stall !== 5'b11111) begin n_fail++; $display("FAIL reset_stall got=%b exp=11111", stall); end
    n_vec++; if (phase_idx !== 3'd0) begin n_fail++; $display("FAIL reset_idx got=%0d exp=0", phase_idx); end
    n_vec++; if ({retire, halted, err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", {retire, halted, err}); end
    n_vec++; if (cycle_cnt !== '0 || instret_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", cycle_cnt, instret_cnt); end
  endtask

  task automatic test_no_wait;
    do_reset();
    start_run();
    for (int k = 0; k < NPHASE; k++) begin
      n_vec++; if (phase !== NPHASE'(1 << k)) begin n_fail++; $display("FAIL nowait_phase k=%0d got=%b exp=%b", k, phase, NPHASE'(1 << k)); end
      n_vec++; if (stall !== ~NPHASE'(1 << k)) begin n_fail++; $display("FAIL nowait_stall k=%0d got=%b", k, stall); end
      n_vec++; if (phase_idx !== IDX_W'(k)) begin n_fail++; $display("FAIL nowait_idx k=%0d got=%0d exp=%0d", k, phase_idx, k); end
      n_vec++; if (retire !== (k == NPHASE - 1)) begin n_fail++; $display("FAIL nowait_retire k=%0d got=%b", k, retire); end
      step();
    end
    n_vec++; if (phase !== 5'b00001) begin n_fail++; $display("FAIL nowait_wrap got=%b exp=00001", phase); end
    n_vec++; if (instret_cnt !== perf(1)) begin n_fail++; $display("FAIL nowait_instret got=%0d exp=%0d", instret_cnt, perf(1)); end
    n_vec++; if (cycle_cnt !== perf(5)) begin n_fail++; $display("FAIL nowait_cycles got=%0d exp=%0d", cycle_cnt, perf(5)); end
  endtask

  task automatic test_wait;
    do_reset();
    start_run();
    repeat (3) step();
    wait_req = 5'b01000;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin wait_req = '0; #1; end
      n_vec++; if (phase !== 5'b01000) begin n_fail++; $display("FAIL wait_hold k=%0d got=%b exp=01000", k, phase); end
      n_vec++; if (retire !== 1'b0) begin n_fail++; $display("FAIL wait_retire k=%0d got=%b exp=0", k, retire); end
      step();
    end
    n_vec++; if (phase !== 5'b10000 || retire !== 1'b1) begin n_fail++; $display("FAIL wait_last got=%b/%b exp=10000/1", phase, retire); end
    step();
    n_vec++; if (cycle_cnt !== perf(8)) begin n_fail++; $display("FAIL wait_cycles got=%0d exp=%0d", cycle_cnt, perf(8)); end
    n_vec++; if (instret_cnt !== perf(1)) begin n_fail++; $display("FAIL wait_instret got=%0d exp=%0d", instret_cnt, perf(1)); end
  endtask

  task automatic test_flush;
    do_reset();
    start_run();
    repeat (2) step();
    flush = 1'b1; wait_req = 5'b00100;
    #1;
    n_vec++; if (phase !== 5'b00100 || retire !== 1'b0) begin n_fail++; $display("FAIL flush_pre got=%b/%b exp=00100/0", phase, retire); end
    step();
    flush = 1'b0; wait_req = '0;
    #1;
    n_vec++; if (phase !== 5'b00001 || phase_idx !== 3'd0) begin n_fail++; $display("FAIL flush_restart got=%b/%0d exp=00001/0", phase, phase_idx); end
    n_vec++; if (instret_cnt !== perf(0)) begin n_fail++; $display("FAIL flush_instret got=%0d exp=%0d", instret_cnt, perf(0)); end
    n_vec++; if (cycle_cnt !== perf(3)) begin n_fail++; $display("FAIL flush_cycles got=%0d exp=%0d", cycle_cnt, perf(3)); end
  endtask

  task automatic test_halt;
    do_reset();
    start_run();
    step();
    halt_req = 1'b1;
    #1;
    repeat (3) step();
    n_vec++; if (phase !== 5'b10000 || retire !== 1'b1) begin n_fail++; $display("FAIL halt_retire got=%b/%b exp=10000/1", phase, retire); end
    step();
    n_vec++; if (halted !== 1'b1 || phase !== 5'b00000 || stall !== 5'b11111) begin n_fail++; $display("FAIL halt_enter got=%b/%b exp=1/00000", halted, phase); end
    step();
    n_vec++; if (halted !== 1'b1 || phase !== 5'b00000) begin n_fail++; $display("FAIL halt_stay got=%b/%b exp=1/00000", halted, phase); end
    resume = 1'b1;
    step();
    resume = 1'b0; halt_req = 1'b0;
    #1;
    n_vec++; if (halted !== 1'b0 || phase !== 5'b00001) begin n_fail++; $display("FAIL halt_resume got=%b/%b exp=0/00001", halted, phase); end
    n_vec++; if (instret_cnt !== perf(1) || cycle_cnt !== perf(5)) begin n_fail++; $display("FAIL halt_cnt got=%0d/%0d exp=%0d/%0d", instret_cnt, cycle_cnt, perf(1), perf(5)); end
  endtask

  task automatic test_watchdog;
    do_reset();
    start_run();
    step();
    wait_req = 5'b00010;
    #1;
    for (int k = 0; k < MAX_WAIT; k++) begin
      n_vec++; if (phase !== 5'b00010 || err !== 1'b0) begin n_fail++; $display("FAIL wd_hold k=%0d got=%b/%b exp=00010/0", k, phase, err); end
      step();
    end
    n_vec++; if (err !== 1'b1 || phase !== 5'b00000) begin n_fail++; $display("FAIL wd_timeout got=%b/%b exp=1/00000", err, phase); end
    start = 1'b1; flush = 1'b1; resume = 1'b1;
    step();
    start = 1'b0; flush = 1'b0; resume = 1'b0;
    #1;
    n_vec++; if (err !== 1'b1 || phase !== 5'b00000) begin n_fail++; $display("FAIL wd_ignore got=%b/%b exp=1/00000", err, phase); end
    clr_err = 1'b1;
    step();
    clr_err = 1'b0; wait_req = '0;
    #1;
    n_vec++; if (err !== 1'b0 || phase !== 5'b00000) begin n_fail++; $display("FAIL wd_clear got=%b/%b exp=0/00000", err, phase); end
    start_run();
    n_vec++; if (phase !== 5'b00001) begin n_fail++; $display("FAIL wd_restart got=%b exp=00001", phase); end
  endtask

  task automatic test_async_reset;
    do_reset();
    start_run();
    repeat (3) step();
    n_vec++; if (phase !== 5'b01000) begin n_fail++; $display("FAIL arst_pre got=%b exp=01000", phase); end
    #2 rst = 1'b1;
    #1;
    n_vec++; if (phase !== 5'b00000 || stall !== 5'b11111) begin n_fail++; $display("FAIL arst_phase got=%b/%b exp=00000/11111", phase, stall); end
    n_vec++; if (err !== 1'b0 || phase_idx !== 3'd0) begin n_fail++; $display("FAIL arst_state got=%b/%0d exp=0/0", err, phase_idx); end
    n_vec++; if (cycle_cnt !== '0 || instret_cnt !== '0) begin n_fail++; $display("FAIL arst_cnt got=%0d/%0d exp=0/0", cycle_cnt, instret_cnt); end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_no_wait();
    test_wait();
    test_flush();
    test_halt();
    test_watchdog();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
